// File: rtl/tb_delay_line.sv
// Programmable delay line: latency = active depth in enabled cycles (depth 0 = combinational bypass).
// Backpressure: i_en low stalls every register; there is no ready, the producer must honour the stall.
module tb_delay_line #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 1,
    parameter int MAX_DEPTH = 6,
    localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic                      i_flush,
    input  logic [DW-1:0]             i_depth,
    input  logic                      i_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_din,
    output logic                      o_valid,
    output logic [CHANNELS*WIDTH-1:0] o_dout,
    output logic [DW-1:0]             o_occupancy,
    output logic                      o_primed
);

    localparam int DATA_W = CHANNELS * WIDTH;

    logic [DATA_W-1:0]    stage_dat [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] stage_vld;
    logic [DW-1:0]        active_depth;
    logic [DW-1:0]        fill_cnt;
    logic [DW-1:0]        occupancy;

    logic [DW-1:0]        depth_clamped;
    logic                 flush_any;
    logic [DATA_W-1:0]    tap_dat;
    logic                 tap_vld;

    assign depth_clamped = (i_depth > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : i_depth;
    // Compare against the clamped value so an over-range request held steady does not flush every cycle.
    assign flush_any     = i_flush | (depth_clamped != active_depth);

    always_comb begin
        tap_dat = '0;
        tap_vld = 1'b0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (active_depth == DW'(k + 1)) begin
                tap_dat = stage_dat[k];
                tap_vld = stage_vld[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                stage_dat[k] <= '0;
            end
            stage_vld    <= '0;
            active_depth <= depth_clamped;
            fill_cnt     <= '0;
            occupancy    <= '0;
        end else if (i_en) begin
            // Data keeps shifting through a flush; only the qualifiers are cleared.
            stage_dat[0] <= i_din;
            stage_vld[0] <= i_valid & ~flush_any;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                stage_dat[k] <= stage_dat[k-1];
                stage_vld[k] <= stage_vld[k-1] & ~flush_any;
            end
            if (flush_any) begin
                active_depth <= depth_clamped;
                fill_cnt     <= '0;
                occupancy    <= '0;
            end else begin
                if (fill_cnt != active_depth) begin
                    fill_cnt <= fill_cnt + DW'(1);
                end
                if (active_depth != '0) begin
                    if (i_valid && !tap_vld) begin
                        occupancy <= occupancy + DW'(1);
                    end else if (!i_valid && tap_vld) begin
                        occupancy <= occupancy - DW'(1);
                    end
                end
            end
        end
    end

    assign o_dout      = (active_depth == '0) ? i_din   : tap_dat;
    assign o_valid     = (active_depth == '0) ? i_valid : tap_vld;
    assign o_occupancy = occupancy;
    assign o_primed    = (fill_cnt == active_depth);

endmodule

// File: tb/tb_tb_delay_line.sv
// Bench for tb_delay_line (WIDTH 4, CHANNELS 2, MAX_DEPTH 6): directed scenarios with literal
// expectations, then randomized traffic, all checked each cycle against a history-based model.
module tb_tb_delay_line;

    localparam int DW     = 3;
    localparam int DATA_W = 8;
    localparam int MAXD   = 6;

    logic              clk = 1'b0;
    logic              rst_n, en, flush, vld;
    logic [DW-1:0]     depth;
    logic [DATA_W-1:0] din;
    logic              o_valid;
    logic [DATA_W-1:0] o_dout;
    logic [DW-1:0]     o_occupancy;
    logic              o_primed;

    int checks = 0;
    int errors = 0;

    tb_delay_line #(.WIDTH(4), .CHANNELS(2), .MAX_DEPTH(MAXD)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_en        (en),
        .i_flush     (flush),
        .i_depth     (depth),
        .i_valid     (vld),
        .i_din       (din),
        .o_valid     (o_valid),
        .o_dout      (o_dout),
        .o_occupancy (o_occupancy),
        .o_primed    (o_primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every enabled edge records its input; a record is live only if written after the last flush.
    logic [DATA_W-1:0] hist_d [$];
    bit                hist_v [$];
    int                m_depth;
    int                m_since;
    bit                model_ok = 1'b0;

    function automatic int clampd(input int d);
        return (d > MAXD) ? MAXD : d;
    endfunction

    always @(posedge clk) begin : model
        int  nd;
        bit  fl;
        if (!rst_n) begin
            hist_d.delete();
            hist_v.delete();
            for (int k = 0; k < MAXD; k++) begin
                hist_d.push_back('0);
                hist_v.push_back(1'b0);
            end
            m_depth  = clampd(int'(depth));
            m_since  = 0;
            model_ok = 1'b1;
        end else if (en && model_ok) begin
            nd = clampd(int'(depth));
            fl = flush || (nd != m_depth);
            hist_d.push_front(din);
            hist_v.push_front(vld);
            void'(hist_d.pop_back());
            void'(hist_v.pop_back());
            if (fl) begin
                m_depth = nd;
                m_since = 0;
            end else begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [DATA_W-1:0] e_d;
        logic              e_v;
        logic              e_p;
        int                e_o;
        int                j;
        if (model_ok) begin
            e_o = 0;
            if (m_depth == 0) begin
                e_d = din;
                e_v = vld;
                e_p = 1'b1;
            end else begin
                j   = m_depth - 1;
                e_d = hist_d[j];
                e_v = hist_v[j] && (j < m_since);
                e_p = (m_since >= m_depth);
                for (int k = 0; k < m_depth; k++) begin
                    if (hist_v[k] && (k < m_since)) e_o++;
                end
            end
            chk("model_valid", 32'(o_valid), 32'(e_v));
            chk("model_dout", 32'(o_dout), 32'(e_d));
            chk("model_occupancy", 32'(o_occupancy), 32'(e_o));
            chk("model_primed", 32'(o_primed), 32'(e_p));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic f, input logic v,
                       input logic [DATA_W-1:0] d, input logic [DW-1:0] dp);
        rst_n = r;
        en    = e;
        flush = f;
        vld   = v;
        din   = d;
        depth = dp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] cur_depth;

        cyc(0, 0, 0, 0, 8'h00, 3'd6);
        cyc(0, 0, 0, 0, 8'h00, 3'd6);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_dout", 32'(o_dout), 32'd0);
        chk("reset_occ", 32'(o_occupancy), 32'd0);
        chk("reset_primed", 32'(o_primed), 32'd0);

        for (int i = 1; i <= 12; i++) begin
            cyc(1, 1, 0, 1, 8'(i), 3'd6);
            chk("d6_occ", 32'(o_occupancy), 32'((i < 6) ? i : 6));
            chk("d6_valid", 32'(o_valid), 32'(i >= 6));
            chk("d6_primed", 32'(o_primed), 32'(i >= 6));
            if (i >= 6) chk("d6_dout", 32'(o_dout), 32'(i - 5));
        end

        cyc(1, 1, 0, 0, 8'h00, 3'd3);
        chk("d3_change_occ", 32'(o_occupancy), 32'd0);
        cyc(1, 1, 0, 1, 8'h0A, 3'd3);
        cyc(1, 1, 0, 1, 8'h0B, 3'd3);
        chk("d3_occ_ab", 32'(o_occupancy), 32'd2);
        for (int s = 0; s < 2; s++) begin
            cyc(1, 0, 1, 1, 8'h0F, 3'd5);
            chk("stall_occ", 32'(o_occupancy), 32'd2);
            chk("stall_valid", 32'(o_valid), 32'd0);
            chk("stall_primed", 32'(o_primed), 32'd0);
        end
        cyc(1, 1, 0, 1, 8'h0C, 3'd3);
        chk("d3_a_valid", 32'(o_valid), 32'd1);
        chk("d3_a_dout", 32'(o_dout), 32'h0A);
        chk("d3_primed", 32'(o_primed), 32'd1);
        cyc(1, 1, 0, 0, 8'h00, 3'd3);
        chk("d3_b_dout", 32'(o_dout), 32'h0B);
        cyc(1, 1, 0, 0, 8'h00, 3'd3);
        chk("d3_c_dout", 32'(o_dout), 32'h0C);
        chk("d3_tail_occ", 32'(o_occupancy), 32'd1);

        cyc(1, 1, 0, 0, 8'h00, 3'd4);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 1, 8'(i), 3'd4);
        chk("d4_occ", 32'(o_occupancy), 32'd4);
        cyc(1, 1, 0, 1, 8'h05, 3'd2);
        chk("d4to2_valid", 32'(o_valid), 32'd0);
        chk("d4to2_occ", 32'(o_occupancy), 32'd0);
        chk("d4to2_primed", 32'(o_primed), 32'd0);
        cyc(1, 1, 0, 1, 8'h06, 3'd2);
        chk("d2_primed_1", 32'(o_primed), 32'd0);
        chk("d2_valid_1", 32'(o_valid), 32'd0);
        cyc(1, 1, 0, 1, 8'h07, 3'd2);
        chk("d2_primed_2", 32'(o_primed), 32'd1);
        chk("d2_dout_2", 32'(o_dout), 32'h06);
        cyc(1, 1, 0, 1, 8'h08, 3'd2);
        chk("d2_dout_3", 32'(o_dout), 32'h07);

        cyc(1, 1, 0, 1, 8'h5A, 3'd0);
        chk("d0_dout", 32'(o_dout), 32'h5A);
        chk("d0_valid", 32'(o_valid), 32'd1);
        chk("d0_occ", 32'(o_occupancy), 32'd0);
        chk("d0_primed", 32'(o_primed), 32'd1);
        din = 8'hC3;
        vld = 1'b0;
        #1;
        chk("d0_comb_dout", 32'(o_dout), 32'hC3);
        chk("d0_comb_valid", 32'(o_valid), 32'd0);

        cyc(1, 1, 0, 0, 8'h00, 3'd5);
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, (i % 2) == 0, 8'(8'h10 + i), 3'd5);
        chk("alt_occ", 32'(o_occupancy), 32'd2);
        cyc(1, 1, 1, 1, 8'hEE, 3'd5);
        chk("flush_occ", 32'(o_occupancy), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_primed", 32'(o_primed), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 8'(8'h20 + i), 3'd5);
            chk("post_flush_valid", 32'(o_valid), 32'd0);
            chk("post_flush_occ", 32'(o_occupancy), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0, (i % 2) == 0, 8'(8'h30 + i), 3'd5);
            if (i == 4) begin
                chk("alt2_dout", 32'(o_dout), 32'h30);
                chk("alt2_valid", 32'(o_valid), 32'd1);
                chk("alt2_occ", 32'(o_occupancy), 32'd3);
            end
        end

        cyc(1, 1, 0, 0, 8'h00, 3'd6);
        for (int i = 1; i <= 6; i++) cyc(1, 1, 0, 1, 8'(8'h40 + i), 3'd6);
        chk("full_occ", 32'(o_occupancy), 32'd6);
        cyc(0, 0, 0, 1, 8'h77, 3'd7);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_dout", 32'(o_dout), 32'd0);
        chk("midrst_occ", 32'(o_occupancy), 32'd0);
        chk("midrst_primed", 32'(o_primed), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 1, 0, 1, 8'(8'h50 + i), 3'd7);
            chk("clamp_primed", 32'(o_primed), 32'(i == 6));
            chk("clamp_valid", 32'(o_valid), 32'(i == 6));
        end
        chk("clamp_dout", 32'(o_dout), 32'h51);
        chk("clamp_occ", 32'(o_occupancy), 32'd6);

        cur_depth = 3'd4;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) cur_depth = DW'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 1) == 1,
                DATA_W'($urandom),
                cur_depth);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
